uart_rx_oversample: RTL and testbench

//  UART receiver that consumes the 16x-oversampled rx_en tick from the baud rate generator.
//  It frames 8N1 serial data: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
//  It presents each received byte with a one-cycle valid strobe and flags framing errors.
//  It sits between the pad-side rx line and the downstream byte consumer (FIFO or command parser).

---
 rtl/uart_rx_oversample_pkg.sv | 17 +
 rtl/uart_rx_oversample_sync_ff.sv | 27 ++
 rtl/uart_rx_oversample.sv | 147 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_oversample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_oversample_sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; resets to a chosen idle level.
// Latency: STAGES clk cycles from i_d to o_q.
// Backpressure: none, free-running every cycle.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the chain; reset to the line's idle level so no false start is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1-style UART receiver driven by an oversample tick; emits a byte strobe or a framing-error strobe.
// Latency: strobes assert on the clk edge after the tick that samples the middle of the stop bit.
// Backpressure: none; the consumer must accept each one-cycle data_valid pulse.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_e            r_state, w_state_nxt;
  logic [CW-1:0]        r_samp_cnt, w_samp_cnt_nxt;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic                 w_load, w_ferr;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid, r_frame_err;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  // Next-state, counter and shift-register updates; nothing moves except on an oversample tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_samp_cnt_nxt = r_samp_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shreg_nxt    = r_shreg;
    w_load         = 1'b0;
    w_ferr         = 1'b0;
    if (rx_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt    = ST_START;
            w_samp_cnt_nxt = '0;
          end
        end
        ST_START: begin
          // Half a bit after the falling edge: a high line here means it was only a glitch.
          if (r_samp_cnt == HALF_LAST) begin
            w_samp_cnt_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt   = ST_DATA;
              w_bit_idx_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_samp_cnt_nxt = r_samp_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_samp_cnt == FULL_LAST) begin
            w_samp_cnt_nxt = '0;
            w_shreg_nxt    = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            if (r_bit_idx == LAST_BIT) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + BW'(1);
            end
          end else begin
            w_samp_cnt_nxt = r_samp_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge half a bit later is still caught.
          if (r_samp_cnt == FULL_LAST) begin
            w_samp_cnt_nxt = '0;
            w_state_nxt    = ST_IDLE;
            if (w_rx_s) begin
              w_load = 1'b1;
            end else begin
              w_ferr = 1'b1;
            end
          end else begin
            w_samp_cnt_nxt = r_samp_cnt + CW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample counter, bit index and receive shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_cnt <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
    end else begin
      r_samp_cnt <= w_samp_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shreg    <= w_shreg_nxt;
    end
  end

  // Output byte and one-cycle strobes; a framing error leaves the last good byte in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_load;
      r_frame_err  <= w_ferr;
      if (w_load) begin
        r_data_out <= r_shreg;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: table of frames plus glitch, reset and break sequences.
// Latency: strobes are matched against a scoreboard whenever they appear.
// Backpressure: n/a.
module tb_uart_rx_oversample;

  localparam int OS  = 16;
  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cycles = 0;
  logic [7:0] last_good;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_strobe(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb.push_back(e);
  endtask

  // One clock: sample outputs on the falling edge, score strobes, then schedule the next rx_en.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (busy) busy_cycles++;
    if (data_valid || frame_err) begin
      check("strobe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h, expected none (cycle %0d)",
                 data_valid, frame_err, data_out, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
      end
    end
    rx_en = ((cyc % DIV) == 0);
    cyc++;
  endtask

  task automatic send_bit(input logic v, input int nt);
    int n;
    rx = v;
    n  = 0;
    while (n < nt) begin
      step();
      if (rx_en) n++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
    send_bit(stop, OS);
  endtask

  task automatic idle_bits(input int n);
    send_bit(1'b1, n * OS);
  endtask

  initial begin
    // data, stop level, idle bits after, expected error flag, expected data_out at strobe
    vecs[0] = '{8'h55, 1'b1, 2, 1'b0, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 0, 1'b0, 8'hA3};
    vecs[2] = '{8'h0F, 1'b1, 2, 1'b0, 8'h0F};
    vecs[3] = '{8'h3C, 1'b0, 2, 1'b1, 8'h0F};
    vecs[4] = '{8'h00, 1'b1, 1, 1'b0, 8'h00};
    vecs[5] = '{8'h80, 1'b1, 0, 1'b0, 8'h80};
    vecs[6] = '{8'h01, 1'b1, 1, 1'b0, 8'h01};
    vecs[7] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};

    rst   = 1'b1;
    rx    = 1'b1;
    rx_en = 1'b0;
    repeat (4) step();
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Frame table: good bytes, back-to-back pairs and a low stop bit.
    for (int i = 0; i < 8; i++) begin
      expect_strobe(vecs[i].exp_err, vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle_bits(vecs[i].gap);
    end
    check("table_pending", sb.size(), 32'd0);
    check("table_idle_busy", {31'd0, busy}, 32'd0);
    last_good = 8'hFF;

    // Short low glitch: busy for exactly the 8 ticks up to the mid-start check, no strobe.
    busy_cycles = 0;
    send_bit(1'b0, 5);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    idle_bits(2);
    check("glitch_busy_cycles", busy_cycles, 8 * DIV);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x81.
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(1'b1, OS);
    send_bit(1'b1, OS / 2);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_data_out", {24'd0, data_out}, 32'd0);
    idle_bits(1);
    expect_strobe(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("after_reset_pending", sb.size(), 32'd0);
    last_good = 8'h81;

    // Break: a frame is 153 ticks, so 29 bit times give three framing errors and the
    // release lands inside the fourth frame's start bit, which is then rejected as a glitch.
    for (int i = 0; i < 3; i++) expect_strobe(1'b1, last_good);
    send_bit(1'b0, 29 * OS);
    idle_bits(3);
    check("break_pending", sb.size(), 32'd0);
    check("break_busy", {31'd0, busy}, 32'd0);
    check("break_data_out", {24'd0, data_out}, {24'd0, last_good});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
